// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline-stage registers of the 5-stage
// RISC-V core.
//   - pipe_state_e  : occupancy of a stage register (EMPTY / ONE / FULL)
//   - PIPE_*_WIDTH  : default payload/statistics widths of a generic stage
//   - FD_/DE_/EM_/MW_* : default widths for each concrete stage instance
//   - ps_can_accept : whether a stage in a given occupancy may take a new entry
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_WIDTH = 32;
    localparam int PIPE_CTRL_WIDTH = 8;
    localparam int PIPE_STAT_WIDTH = 32;

    // Fetch -> Decode: instruction, PC, PC+4
    localparam int FD_CTRL_WIDTH = 1;
    localparam int FD_DATA_WIDTH = 96;
    // Decode -> Execute: two operands, immediate, PC, PC+4, rd
    localparam int DE_CTRL_WIDTH = 12;
    localparam int DE_DATA_WIDTH = 165;
    // Execute -> Memory: ALU result, write data, PC+4, rd
    localparam int EM_CTRL_WIDTH = 5;
    localparam int EM_DATA_WIDTH = 101;
    // Memory -> Writeback: ALU result, read data, PC+4, rd
    localparam int MW_CTRL_WIDTH = 3;
    localparam int MW_DATA_WIDTH = 101;

    // A new entry fits as long as the skid slot is still free.
    function automatic logic ps_can_accept(input pipe_state_e state);
        return state != PS_FULL;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Width-parametrised up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock, counts on rising edge
//   rst_n  - asynchronous active-low reset, clears the count
//   en     - increment request for this cycle
//   count  - current count value
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment only while below the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline-stage register with a valid/ready handshake and a one-entry
// skid slot behind the main register, so in_ready is a flop and never depends
// combinationally on out_ready. FLUSH turns every held entry into a bubble by
// clearing its control field; data fields are left untouched.
//
// Optional feature: define PIPE_SKID_STATS_EN to build a saturating counter of
// stall cycles (out_valid=1, out_ready=0) on stall_cnt; otherwise stall_cnt
// is tied to zero and no counter is built.
//
// Ports:
//   CLK        - clock, all state on rising edge
//   RST_N      - asynchronous active-low reset
//   FLUSH      - synchronous kill of all held entries (drops the input too)
//   in_valid   - upstream entry valid
//   in_ready   - stage can accept (registered)
//   in_ctrl    - upstream control field
//   in_data    - upstream data field
//   out_valid  - downstream entry valid
//   out_ready  - downstream accepts (low = stall)
//   out_ctrl   - control field, zero whenever out_valid=0
//   out_data   - data field
//   stall_cnt  - stall-cycle count
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int CTRL_WIDTH = PIPE_CTRL_WIDTH,
    parameter int STAT_WIDTH = PIPE_STAT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FLUSH,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [STAT_WIDTH-1:0] stall_cnt
);

    pipe_state_e           state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic accept;
    logic emit;

    // The main register is the output stage, so it is valid whenever the
    // stage holds anything at all.
    assign out_valid = (state_q != PS_EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign in_ready  = in_ready_q;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid & out_ready;

    // Occupancy and payload movement. Control fields are zeroed whenever a
    // slot is vacated so an empty slot always reads as a bubble; data fields
    // are only ever overwritten by new entries. in_ready is precomputed from
    // the next occupancy so it can be registered.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (FLUSH) begin
            state_d     = PS_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (accept && emit) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = PS_FULL;
                    end else if (emit) begin
                        main_ctrl_d = '0;
                        state_d     = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (emit) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        state_d     = PS_ONE;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                    state_d     = PS_EMPTY;
                end
            endcase
        end

        in_ready_d = ps_can_accept(state_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= PS_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    // Stall counter survives FLUSH; only reset clears it.
    pipe_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg. A directed vector table covers
// streaming, skid fill and flush; hand-written sequences cover asynchronous
// reset and the stall counter (including a 3-bit instance for saturation);
// a long random run is checked against a capacity-2 FIFO reference model.
// Honours PIPE_SKID_STATS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int SW = 32;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          FLUSH;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] stall_cnt;

    logic          small_in_ready;
    logic          small_out_valid;
    logic [CW-1:0] small_out_ctrl;
    logic [DW-1:0] small_out_data;
    logic [2:0]    small_stall_cnt;

    pipe_skid_reg #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .STAT_WIDTH (SW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    // Same stimulus, narrow stall counter to reach saturation quickly.
    pipe_skid_reg #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .STAT_WIDTH (3)
    ) dut_small (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (small_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (small_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (small_out_ctrl),
        .out_data  (small_out_data),
        .stall_cnt (small_stall_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: the stage is a FIFO of capacity two.
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          fifo[$];
    logic [SW-1:0] stallModel;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic          er;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mkVec(input logic iv, input logic [CW-1:0] ic,
                                   input logic [DW-1:0] id, input logic ordy,
                                   input logic fl, input logic ev, input logic er,
                                   input logic [CW-1:0] ec, input logic [DW-1:0] ed);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] expStall();
`ifdef PIPE_SKID_STATS_EN
        return stallModel;
`else
        return '0;
`endif
    endfunction

    // Advance the model by the clock edge that is about to consume the
    // currently driven inputs.
    task automatic modelStep();
        logic doEmit;
        logic doAccept;
        doEmit   = (fifo.size() > 0) && out_ready;
        doAccept = in_valid && (fifo.size() < 2);
        if ((fifo.size() > 0) && !out_ready && (stallModel != {SW{1'b1}}))
            stallModel++;
        if (FLUSH) begin
            fifo.delete();
        end else begin
            if (doEmit) fifo.delete(0);
            if (doAccept) begin
                ent_t e;
                e.c = in_ctrl;
                e.d = in_data;
                fifo.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [CW-1:0] ic,
                                 input logic [DW-1:0] id, input logic ordy,
                                 input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        FLUSH     = fl;
        modelStep();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " out_valid"}, out_valid, fifo.size() > 0);
        checkOutput({tag, " in_ready"}, in_ready, fifo.size() < 2);
        checkOutput({tag, " out_ctrl"}, out_ctrl, (fifo.size() > 0) ? fifo[0].c : '0);
        if (fifo.size() > 0)
            checkOutput({tag, " out_data"}, out_data, fifo[0].d);
        checkOutput({tag, " stall_cnt"}, stall_cnt, expStall());
    endtask

    task automatic doReset();
        RST_N     = 1'b0;
        FLUSH     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        fifo.delete();
        stallModel = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Streaming, skid fill, flush in FULL, flush dropping input, restart.
        vecs[0]  = mkVec(1, 8'h01, 32'h10, 1, 0, 1, 1, 8'h01, 32'h10);
        vecs[1]  = mkVec(1, 8'h02, 32'h11, 1, 0, 1, 1, 8'h02, 32'h11);
        vecs[2]  = mkVec(1, 8'h03, 32'h12, 1, 0, 1, 1, 8'h03, 32'h12);
        vecs[3]  = mkVec(1, 8'h04, 32'h13, 1, 0, 1, 1, 8'h04, 32'h13);
        vecs[4]  = mkVec(0, 8'h77, 32'h77, 1, 0, 0, 1, 8'h00, 32'h0);
        vecs[5]  = mkVec(1, 8'h0A, 32'hA,  1, 0, 1, 1, 8'h0A, 32'hA);
        vecs[6]  = mkVec(1, 8'h0B, 32'hB,  0, 0, 1, 0, 8'h0A, 32'hA);
        vecs[7]  = mkVec(1, 8'h0F, 32'hF,  0, 0, 1, 0, 8'h0A, 32'hA);
        vecs[8]  = mkVec(0, 8'h55, 32'h55, 1, 0, 1, 1, 8'h0B, 32'hB);
        vecs[9]  = mkVec(0, 8'h66, 32'h66, 1, 0, 0, 1, 8'h00, 32'h0);
        vecs[10] = mkVec(1, 8'h0C, 32'hC,  0, 0, 1, 1, 8'h0C, 32'hC);
        vecs[11] = mkVec(1, 8'h0D, 32'hD,  0, 0, 1, 0, 8'h0C, 32'hC);
        vecs[12] = mkVec(1, 8'h0E, 32'hE,  0, 1, 0, 1, 8'h00, 32'h0);
        vecs[13] = mkVec(0, 8'h00, 32'h0,  1, 0, 0, 1, 8'h00, 32'h0);
        vecs[14] = mkVec(1, 8'h20, 32'h20, 1, 0, 1, 1, 8'h20, 32'h20);
        vecs[15] = mkVec(1, 8'h21, 32'h21, 1, 1, 0, 1, 8'h00, 32'h0);
        vecs[16] = mkVec(0, 8'h00, 32'h0,  1, 0, 0, 1, 8'h00, 32'h0);
        vecs[17] = mkVec(1, 8'h22, 32'h22, 0, 0, 1, 1, 8'h22, 32'h22);

        doReset();
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset out_ctrl", out_ctrl, 8'h0);
        checkOutput("reset out_data", out_data, 32'h0);
        checkOutput("reset in_ready", in_ready, 1'b1);
        checkOutput("reset stall_cnt", stall_cnt, 32'h0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            checkOutput($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ev);
            checkOutput($sformatf("vec%0d in_ready", i), in_ready, vecs[i].er);
            checkOutput($sformatf("vec%0d out_ctrl", i), out_ctrl, vecs[i].ec);
            if (vecs[i].ev)
                checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].ed);
            checkOutput($sformatf("vec%0d stall_cnt", i), stall_cnt, expStall());
        end

        // Fill the skid slot, then pull reset between clock edges.
        applyStimulus(1, 8'h31, 32'h31, 0, 0);
        checkModel("full-before-reset");
        in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid, 1'b0);
        checkOutput("async reset out_ctrl", out_ctrl, 8'h0);
        checkOutput("async reset out_data", out_data, 32'h0);
        checkOutput("async reset in_ready", in_ready, 1'b1);
        checkOutput("async reset stall_cnt", stall_cnt, 32'h0);
        fifo.delete();
        stallModel = '0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        applyStimulus(0, 8'h0, 32'h0, 1, 0);
        checkModel("after-async-reset");

        // Stall counter: 5 cycles, then 10 (narrow instance saturates at 7).
        doReset();
        applyStimulus(1, 8'h41, 32'h41, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 8'h0, 32'h0, 0, 0);
`ifdef PIPE_SKID_STATS_EN
        checkOutput("stall 5 cycles", stall_cnt, 32'd5);
        checkOutput("stall 5 cycles narrow", small_stall_cnt, 3'd5);
`else
        checkOutput("stall 5 cycles", stall_cnt, 32'd0);
        checkOutput("stall 5 cycles narrow", small_stall_cnt, 3'd0);
`endif
        for (int i = 0; i < 5; i++) applyStimulus(0, 8'h0, 32'h0, 0, 0);
`ifdef PIPE_SKID_STATS_EN
        checkOutput("stall 10 cycles", stall_cnt, 32'd10);
        checkOutput("stall saturate narrow", small_stall_cnt, 3'd7);
`else
        checkOutput("stall 10 cycles", stall_cnt, 32'd0);
        checkOutput("stall saturate narrow", small_stall_cnt, 3'd0);
`endif
        checkOutput("narrow out_valid", small_out_valid, 1'b1);
        checkOutput("narrow out_ctrl", small_out_ctrl, 8'h41);
        checkOutput("narrow out_data", small_out_data, 32'h41);
        checkOutput("narrow in_ready", small_in_ready, 1'b1);
        // Flush must not clear the stall count.
        applyStimulus(0, 8'h0, 32'h0, 0, 1);
        checkModel("stall-after-flush");

        // Random traffic against the FIFO model.
        doReset();
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
